// File: rtl/rpn_stack_eval_if.sv
// Token/result bundle between the RPN parser front end and the evaluator.
// The master side is upstream: it sends tokens and watches results.
interface rpn_stack_eval_if #(
  parameter int W     = 16,
  parameter int DEPTH = 8
);
  localparam int DW = $clog2(DEPTH + 1);

  logic          num_valid;
  logic [W-1:0]  num;
  logic          op_valid;
  logic [3:0]    op;
  logic          eval;
  logic          ready;
  logic          result_valid;
  logic          result_err;
  logic [W-1:0]  result;
  logic [DW-1:0] depth;

  modport master (
    output num_valid, num, op_valid, op, eval,
    input  ready, result_valid, result_err, result, depth
  );

  modport slave (
    input  num_valid, num, op_valid, op, eval,
    output ready, result_valid, result_err, result, depth
  );
endinterface

// File: rtl/rpn_stack_eval.sv
// Reverse-Polish evaluator: operand stack, add/sub/mul on the top two entries,
// one result (or error) per expression on eval.
module rpn_stack_eval #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  rpn_stack_eval_if.slave   bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  typedef enum logic {S_READY, S_EXEC} state_t;

  state_t        state_reg, state_next;
  logic [DW-1:0] depth_reg, depth_next;
  logic          err_reg, err_next;
  logic          pend_reg, pend_next;
  logic [W-1:0]  a_reg, a_next, b_reg, b_next;
  logic [1:0]    opc_reg, opc_next;
  logic [W-1:0]  result_reg, result_next;
  logic          result_valid_reg, result_valid_next;
  logic          result_err_reg, result_err_next;

  logic [W-1:0]  stack_mem [DEPTH];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;

  logic [AW-1:0] top_idx, sec_idx;
  logic [1:0]    n_tok;
  logic          multi, eval_ok;
  logic [W-1:0]  alu;

  assign top_idx = AW'(depth_reg - DW'(1));
  assign sec_idx = AW'(depth_reg - DW'(2));
  assign n_tok   = {1'b0, bus.num_valid} + {1'b0, bus.op_valid} + {1'b0, bus.eval};
  assign multi   = (n_tok > 2'd1);
  assign eval_ok = !err_reg && (depth_reg == DW'(1)) && !multi;

  always_comb begin
    case (opc_reg)
      2'd0:    alu = a_reg + b_reg;
      2'd1:    alu = a_reg - b_reg;
      default: alu = a_reg * b_reg;
    endcase
  end

  always_comb begin
    state_next        = state_reg;
    depth_next        = depth_reg;
    err_next          = err_reg;
    pend_next         = pend_reg;
    a_next            = a_reg;
    b_next            = b_reg;
    opc_next          = opc_reg;
    result_next       = result_reg;
    result_valid_next = 1'b0;
    result_err_next   = result_err_reg;
    wr_en             = 1'b0;
    wr_addr           = AW'(depth_reg);
    wr_data           = bus.num;

    case (state_reg)
      S_READY: begin
        // A pending eval (from the S_EXEC cycle) closes the expression first.
        if (pend_reg || bus.eval) begin
          result_valid_next = 1'b1;
          result_err_next   = !eval_ok;
          result_next       = eval_ok ? stack_mem[0] : '0;
          depth_next        = '0;
          err_next          = 1'b0;
          pend_next         = 1'b0;
        end else if (multi) begin
          err_next = 1'b1;
        end else if (bus.num_valid) begin
          if (depth_reg == FULL) begin
            err_next = 1'b1;
          end else begin
            wr_en      = 1'b1;
            depth_next = depth_reg + DW'(1);
          end
        end else if (bus.op_valid) begin
          if (depth_reg < DW'(2) || bus.op > 4'd2) begin
            err_next = 1'b1;
          end else begin
            a_next     = stack_mem[sec_idx];
            b_next     = stack_mem[top_idx];
            opc_next   = bus.op[1:0];
            state_next = S_EXEC;
          end
        end
      end
      default: begin
        wr_en      = 1'b1;
        wr_addr    = sec_idx;
        wr_data    = alu;
        depth_next = depth_reg - DW'(1);
        state_next = S_READY;
        if (bus.eval)
          pend_next = 1'b1;
        if (bus.num_valid || bus.op_valid)
          err_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= S_READY;
      depth_reg        <= '0;
      err_reg          <= 1'b0;
      pend_reg         <= 1'b0;
      a_reg            <= '0;
      b_reg            <= '0;
      opc_reg          <= '0;
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
      result_err_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      depth_reg        <= depth_next;
      err_reg          <= err_next;
      pend_reg         <= pend_next;
      a_reg            <= a_next;
      b_reg            <= b_next;
      opc_reg          <= opc_next;
      result_reg       <= result_next;
      result_valid_reg <= result_valid_next;
      result_err_reg   <= result_err_next;
    end
  end

  // Stack contents survive reset; only depth defines what is live.
  always_ff @(posedge clk) begin
    if (wr_en)
      stack_mem[wr_addr] <= wr_data;
  end

  assign bus.ready        = (state_reg == S_READY);
  assign bus.result_valid = result_valid_reg;
  assign bus.result_err   = result_err_reg;
  assign bus.result       = result_reg;
  assign bus.depth        = depth_reg;
endmodule

// File: tb/tb_rpn_stack_eval.sv
// Bench for rpn_stack_eval: token table with a result scoreboard, plus
// hand sequences for pending eval, reset during execution and token collisions.
module tb_rpn_stack_eval;
  localparam int KN = 0;
  localparam int KO = 1;
  localparam int KE = 2;

  typedef struct {
    int          kind;
    logic [15:0] val;
    logic [3:0]  exp_depth;
    logic        exp_err;
    logic [15:0] exp_res;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rpn_stack_eval_if #(.W(16), .DEPTH(8)) bus();

  rpn_stack_eval #(.DEPTH(8), .W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [16:0] sb_q[$];
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input int k, input logic [15:0] v, input logic [3:0] d,
                     input logic e, input logic [15:0] r);
    vec_t t;
    t.kind = k; t.val = v; t.exp_depth = d; t.exp_err = e; t.exp_res = r;
    vecs.push_back(t);
  endtask

  task automatic pulse(input logic nv, input logic ov, input logic ev, input logic [15:0] v);
    @(negedge clk);
    bus.num_valid = nv; bus.op_valid = ov; bus.eval = ev;
    bus.num = v; bus.op = v[3:0];
    @(negedge clk);
    bus.num_valid = 1'b0; bus.op_valid = 1'b0; bus.eval = 1'b0;
  endtask

  // Result monitor: every result_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.result_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", {15'd0, bus.result_err, bus.result}, 32'h1FFFF);
      end else begin
        logic [16:0] e;
        e = sb_q.pop_front();
        chk("result", {15'd0, bus.result_err, bus.result}, {15'd0, e});
        $display("result err=%0d value=%0h", bus.result_err, bus.result);
        chk("depth_after_eval", {28'd0, bus.depth}, 32'd0);
      end
    end
  end

  initial begin
    bus.num_valid = 1'b0; bus.op_valid = 1'b0; bus.eval = 1'b0;
    bus.num = '0; bus.op = '0;

    add(KN, 12, 1, 0, 0); add(KN, 2, 2, 0, 0); add(KO, 0, 1, 0, 0); add(KE, 0, 0, 0, 16'd14);
    add(KN, 2, 1, 0, 0); add(KN, 12, 2, 0, 0); add(KO, 1, 1, 0, 0); add(KE, 0, 0, 0, 16'hFFF6);
    add(KN, 300, 1, 0, 0); add(KN, 300, 2, 0, 0); add(KO, 2, 1, 0, 0); add(KE, 0, 0, 0, 16'd24464);
    add(KN, 3, 1, 0, 0); add(KN, 4, 2, 0, 0); add(KO, 0, 1, 0, 0); add(KN, 5, 2, 0, 0);
    add(KO, 2, 1, 0, 0); add(KE, 0, 0, 0, 16'd35);
    add(KN, 5, 1, 0, 0); add(KO, 0, 1, 0, 0); add(KE, 0, 0, 1, 0);
    add(KN, 1, 1, 0, 0); add(KN, 2, 2, 0, 0); add(KE, 0, 0, 1, 0);
    add(KN, 1, 1, 0, 0); add(KN, 2, 2, 0, 0); add(KO, 7, 2, 0, 0); add(KE, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) add(KN, 1, (i < 8) ? 4'(i + 1) : 4'd8, 0, 0);
    for (int i = 0; i < 7; i++) add(KO, 0, 4'(7 - i), 0, 0);
    add(KE, 0, 0, 1, 0);
    add(KN, 7, 1, 0, 0); add(KE, 0, 0, 0, 16'd7);
    add(KE, 0, 0, 1, 0);
    add(KN, 16'hFFFF, 1, 0, 0); add(KN, 1, 2, 0, 0); add(KO, 0, 1, 0, 0); add(KE, 0, 0, 0, 0);
    add(KN, 0, 1, 0, 0); add(KN, 5, 2, 0, 0); add(KO, 1, 1, 0, 0); add(KE, 0, 0, 0, 16'hFFFB);

    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, bus.ready}, 32'd1);
    chk("reset_depth", {28'd0, bus.depth}, 32'd0);
    chk("reset_result_valid", {31'd0, bus.result_valid}, 32'd0);
    chk("reset_result_err", {31'd0, bus.result_err}, 32'd0);
    chk("reset_result", {16'd0, bus.result}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      if (vecs[i].kind == KE) sb_q.push_back({vecs[i].exp_err, vecs[i].exp_res});
      pulse(vecs[i].kind == KN, vecs[i].kind == KO, vecs[i].kind == KE, vecs[i].val);
      repeat (2) @(negedge clk);
      chk($sformatf("depth_vec%0d", i), {28'd0, bus.depth}, {28'd0, vecs[i].exp_depth});
    end

    // eval arriving while the operator executes is held and applied afterwards
    pulse(1, 0, 0, 3); repeat (2) @(negedge clk);
    pulse(1, 0, 0, 4); repeat (2) @(negedge clk);
    @(negedge clk); bus.op_valid = 1'b1; bus.op = 4'd0;
    @(negedge clk); bus.op_valid = 1'b0;
    chk("exec_ready_low", {31'd0, bus.ready}, 32'd0);
    sb_q.push_back({1'b0, 16'd7});
    bus.eval = 1'b1;
    @(negedge clk); bus.eval = 1'b0;
    chk("pend_ready", {31'd0, bus.ready}, 32'd1);
    chk("pend_depth", {28'd0, bus.depth}, 32'd1);
    chk("pend_no_early_valid", {31'd0, bus.result_valid}, 32'd0);
    @(negedge clk);
    chk("pend_valid", {31'd0, bus.result_valid}, 32'd1);
    repeat (2) @(negedge clk);

    // reset in the middle of S_EXEC
    pulse(1, 0, 0, 1); repeat (2) @(negedge clk);
    pulse(1, 0, 0, 1); repeat (2) @(negedge clk);
    @(negedge clk); bus.op_valid = 1'b1; bus.op = 4'd0;
    @(negedge clk); bus.op_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_exec_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_exec_depth", {28'd0, bus.depth}, 32'd0);
    chk("rst_exec_valid", {31'd0, bus.result_valid}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    pulse(1, 0, 0, 1); repeat (2) @(negedge clk);
    pulse(1, 0, 0, 1); repeat (2) @(negedge clk);
    pulse(0, 1, 0, 0); repeat (2) @(negedge clk);
    sb_q.push_back({1'b0, 16'd2});
    pulse(0, 0, 1, 0); repeat (2) @(negedge clk);

    // colliding strobes
    pulse(1, 0, 0, 5); repeat (2) @(negedge clk);
    pulse(1, 1, 0, 6); repeat (2) @(negedge clk);
    chk("collide_depth", {28'd0, bus.depth}, 32'd1);
    sb_q.push_back({1'b1, 16'd0});
    pulse(0, 0, 1, 0); repeat (2) @(negedge clk);
    pulse(1, 0, 0, 9); repeat (2) @(negedge clk);
    sb_q.push_back({1'b1, 16'd0});
    pulse(1, 0, 1, 4); repeat (2) @(negedge clk);
    sb_q.push_back({1'b0, 16'd8});
    pulse(1, 0, 0, 8); repeat (2) @(negedge clk);
    pulse(0, 0, 1, 0); repeat (4) @(negedge clk);

    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/rpn_stack_eval.md
# rpn_stack_eval

Reverse-Polish evaluation stage sitting directly downstream of `digits_to_byte` and `parse_ascii` in the UART RPN calculator path. It consumes completed number tokens, operator tokens and an end-of-expression strobe, maintains an operand stack, executes arithmetic, and emits one result (or an error indication) per expression. Its output feeds the result formatter / UART TX path.

## Interface
- `DEPTH`, 8: operand stack entries (2..16).
- `W`, 16: operand/result width; matches `digits_to_byte` number width.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `num_valid`  in  1  one-cycle strobe: `num` holds a completed number (driven from `number_ready`).
- `num`  in  W  number value.
- `op_valid`  in  1  one-cycle strobe: `op` holds an operator code.
- `op`  in  4  operator: 0 = add, 1 = sub, 2 = mul; all other codes illegal.
- `eval`  in  1  one-cycle strobe: end of expression (newline received).
- `ready`  out  1  block accepts a token this cycle.
- `result_valid`  out  1  one-cycle pulse: expression finished.
- `result_err`  out  1  qualifies `result_valid`: 1 = expression failed, `result` = 0.
- `result`  out  W  result value, held until next `result_valid`.
- `depth`  out  $clog2(DEPTH+1)  current stack occupancy.

## Operation
- States: S_READY (accept tokens), S_EXEC (compute one operator).
- S_READY, `num_valid`: push `num`; depth+1. If depth == DEPTH: drop, set sticky `err`.
- S_READY, `op_valid`: if depth < 2 or illegal code: set `err`, stack unchanged, stay S_READY. Else latch a = entry[depth-2], b = entry[depth-1], go S_EXEC.
- S_EXEC: write f(a,b) to entry[depth-2], depth-1, return to S_READY.
- Arithmetic: unsigned, modulo 2^W. add a+b; sub a−b (second-from-top minus top, i.e. `a b -`); mul low W bits of a*b.
- S_READY, `eval`: if `err` = 0 and depth == 1: `result` = entry[0], `result_err` = 0. Otherwise `result` = 0, `result_err` = 1. In both cases pulse `result_valid`, clear stack (depth 0) and `err`.
- `eval` with depth 0 and no error (empty line): `result_err` = 1.
- More than one of `num_valid`/`op_valid`/`eval` in one cycle: none applied, `err` set; if `eval` among them, expression still terminates with `result_err` = 1.
- Any token while `ready` = 0: ignored, `err` set (except `eval`, which is still honoured on the cycle after S_EXEC completes: it is latched as pending and applied on return to S_READY).
- Reset (any time, including mid-S_EXEC): state S_READY, depth 0, `err` 0, `ready` 1, `result_valid` 0, `result_err` 0, `result` 0. Stack contents need not be cleared.

## Timing
- Number push: accepted cycle T, visible in `depth` at T+1; `ready` stays 1.
- Operator: accepted T; `ready` = 0 at T+1 (S_EXEC); result on stack and `ready` = 1 at T+2. Upstream spacing of ≥2 cycles between tokens is guaranteed by the UART rate (~1085 clk per byte).
- `eval` accepted T: `result_valid`/`result_err`/`result` registered, asserted at T+1 for exactly one cycle; `depth` = 0 at T+1.
- Pending `eval` during S_EXEC: `result_valid` at T+2 where T is the S_EXEC cycle.
- All outputs registered; no combinational input→output paths except none.

## Test plan
- Tokens 12, 2, op 0, eval -> `result_valid` with `result` = 14, `result_err` = 0, `depth` = 0 after.
- 2, 12, op 1, eval -> `result` = 16'hFFF6 (wrap), `result_err` = 0.
- 300, 300, op 2, eval -> `result` = 24464 (90000 mod 65536); then 3, 4, op 0, 5, op 2, eval -> 35.
- 5, op 0, eval -> underflow: `result_err` = 1, `result` = 0; 1, 2, eval (depth 2) -> `result_err` = 1; op 4'd7 -> `result_err` = 1.
- DEPTH+1 = 9 pushes, then ops to reduce, eval -> `result_err` = 1; next expression 7, eval -> 7, `result_err` = 0 (error cleared).
- Assert `rst_n` = 0 during S_EXEC -> `ready` = 1, `depth` = 0, no `result_valid`; then 1, 1, op 0, eval -> 2. Also `op_valid` and `num_valid` same cycle -> next eval `result_err` = 1.
